// File: rtl/fpga_link_rx_if.sv
// Link-side signal bundle for the serial receiver: the peer's serial line plus
// the byte handshake and error strobes seen by the consuming logic.
interface fpga_link_rx_if;
   logic       rx_line;
   logic [7:0] data_out;
   logic       received;
   logic       processed;
   logic       rx_busy;
   logic       parity_error;
   logic       frame_error;

   // Peer/consumer side: drives the line and the ack, observes everything else
   modport master (
      output rx_line,
      output processed,
      input  data_out,
      input  received,
      input  rx_busy,
      input  parity_error,
      input  frame_error
   );

   // Receiver side
   modport slave (
      input  rx_line,
      input  processed,
      output data_out,
      output received,
      output rx_busy,
      output parity_error,
      output frame_error
   );
endinterface

// File: rtl/fpga_link_rx.sv
// Serial link receiver: deserialises start/8-data/parity/stop frames into bytes and
// holds each byte with a received/processed handshake. rx_busy throttles the peer
// while a byte is waiting to be consumed.
module fpga_link_rx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   fpga_link_rx_if.slave link
);

   localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak,
      StHold
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_err_q, par_err_d;
   logic [7:0]      data_out_q, data_out_d;
   logic            received_q, received_d;
   logic            rx_busy_q, rx_busy_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;

   // Synchroniser chain; rs_prev_q is only used for edge detection
   logic sync_q, rs_q, rs_prev_q;
   logic fall;

   // Two-flop synchroniser plus a delayed copy; idle-high after reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q    <= 1'b1;
         rs_q      <= 1'b1;
         rs_prev_q <= 1'b1;
      end else begin
         sync_q    <= link.rx_line;
         rs_q      <= sync_q;
         rs_prev_q <= rs_q;
      end
   end

   assign fall = rs_prev_q & ~rs_q;

   // State, datapath and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         par_err_q  <= 1'b0;
         data_out_q <= '0;
         received_q <= 1'b0;
         rx_busy_q  <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         par_err_q  <= par_err_d;
         data_out_q <= data_out_d;
         received_q <= received_d;
         rx_busy_q  <= rx_busy_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
      end
   end

   // Next-state, bit sampling and handshake decisions
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CntOne;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      par_err_d  = par_err_q;
      data_out_d = data_out_q;
      received_d = received_q;
      rx_busy_d  = rx_busy_q;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (fall) begin
               state_d   = StStart;
               bit_idx_d = '0;
               par_err_d = 1'b0;
            end
         end

         // Re-check the line at mid start bit; a high here was only a glitch
         StStart: begin
            if (cnt_q == CntHalf) begin
               state_d = rs_q ? StIdle : StData;
            end
         end

         StData: begin
            if (cnt_q == CntLast) begin
               shift_d   = {rs_q, shift_q[7:1]};
               cnt_d     = '0;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = PARITY_EN ? StParity : StStop;
               end
            end
         end

         // Even parity: data bits XOR parity bit must be zero
         StParity: begin
            if (cnt_q == CntLast) begin
               par_err_d = ^{shift_q, rs_q};
               state_d   = StStop;
            end
         end

         // A low stop bit outranks a parity mismatch
         StStop: begin
            if (cnt_q == CntLast) begin
               if (!rs_q) begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end else if (par_err_q) begin
                  perr_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  data_out_d = shift_q;
                  received_d = 1'b1;
                  rx_busy_d  = 1'b1;
                  state_d    = StHold;
               end
            end
         end

         // Line held low: wait for it to return high before hunting for a start edge
         StBreak: begin
            cnt_d = '0;
            if (rs_q) begin
               state_d = StIdle;
            end
         end

         // Byte is frozen until the consumer acks; line activity is ignored
         StHold: begin
            cnt_d = '0;
            if (link.processed) begin
               received_d = 1'b0;
               rx_busy_d  = 1'b0;
               state_d    = StIdle;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase

      // Bit timing restarts on every state change
      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   assign link.data_out     = data_out_q;
   assign link.received     = received_q;
   assign link.rx_busy      = rx_busy_q;
   assign link.parity_error = perr_q;
   assign link.frame_error  = ferr_q;

endmodule

// File: tb/tb_fpga_link_rx.sv
// Scoreboard bench for fpga_link_rx: stimulus pushes expected events (bytes and
// error strobes) into a queue; a monitor pops and compares whenever the DUT
// raises received, parity_error or frame_error, and acks bytes when enabled.
module tb_fpga_link_rx;

   localparam int CPB = 16;
   localparam int EvByte   = 0;
   localparam int EvParity = 1;
   localparam int EvFrame  = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } ev_t;

   logic clock;
   logic reset;
   int   n_tests;
   int   n_fail;
   bit   auto_ack;
   ev_t  exp_q[$];

   fpga_link_rx_if rx_if ();

   fpga_link_rx #(
      .CLKS_PER_BIT (CPB),
      .PARITY_EN    (1'b1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .link  (rx_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_ev(input int kind, input logic [7:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic pop_compare(input int kind, input logic [7:0] data);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected event: kind %0d data 0x%0h, expected none (t=%0t)",
                  kind, data, $time);
      end else begin
         e = exp_q.pop_front();
         check("event kind", kind, e.kind);
         if (e.kind == EvByte && kind == EvByte) begin
            check("byte data", {24'd0, data}, {24'd0, e.data});
         end
      end
   endtask

   task automatic idle(input int n);
      rx_if.rx_line = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   // Start, 8 data bits LSB first, parity (even, optionally inverted), stop
   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
      rx_if.rx_line = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx_if.rx_line = d[i];
         repeat (CPB) @(negedge clock);
      end
      rx_if.rx_line = (^d) ^ par_flip;
      repeat (CPB) @(negedge clock);
      rx_if.rx_line = stop_bit;
      repeat (CPB) @(negedge clock);
   endtask

   // Bounded wait for all expected events to be consumed by the monitor
   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clock);
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic manual_ack();
      rx_if.processed = 1'b1;
      @(negedge clock);
      rx_if.processed = 1'b0;
      check("manual ack received", {31'd0, rx_if.received}, 0);
      check("manual ack rx_busy", {31'd0, rx_if.rx_busy}, 0);
   endtask

   // Monitor: compares events against the scoreboard and acts as the consumer
   initial begin : monitor
      logic       rcv_prev;
      logic       pe_prev;
      logic       fe_prev;
      logic [7:0] held;
      rcv_prev = 1'b0;
      pe_prev  = 1'b0;
      fe_prev  = 1'b0;
      forever begin
         @(negedge clock);
         if (pe_prev) check("parity_error width", {31'd0, rx_if.parity_error}, 0);
         if (fe_prev) check("frame_error width", {31'd0, rx_if.frame_error}, 0);
         if (rx_if.parity_error && !pe_prev) pop_compare(EvParity, 8'h00);
         if (rx_if.frame_error && !fe_prev) pop_compare(EvFrame, 8'h00);
         if (rx_if.received && !rcv_prev) begin
            held = rx_if.data_out;
            pop_compare(EvByte, held);
            check("rx_busy with received", {31'd0, rx_if.rx_busy}, 1);
            if (auto_ack) begin
               repeat (3) @(negedge clock);
               check("received held", {31'd0, rx_if.received}, 1);
               check("data_out stable", {24'd0, rx_if.data_out}, {24'd0, held});
               rx_if.processed = 1'b1;
               @(negedge clock);
               rx_if.processed = 1'b0;
               check("received after ack", {31'd0, rx_if.received}, 0);
               check("rx_busy after ack", {31'd0, rx_if.rx_busy}, 0);
            end
         end
         rcv_prev = rx_if.received;
         pe_prev  = rx_if.parity_error;
         fe_prev  = rx_if.frame_error;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [7:0] seq [5];
      n_tests          = 0;
      n_fail           = 0;
      auto_ack         = 1'b1;
      reset            = 1'b1;
      rx_if.rx_line    = 1'b1;
      rx_if.processed  = 1'b0;
      repeat (3) @(negedge clock);
      check("reset data_out", {24'd0, rx_if.data_out}, 0);
      check("reset received", {31'd0, rx_if.received}, 0);
      check("reset rx_busy", {31'd0, rx_if.rx_busy}, 0);
      check("reset parity_error", {31'd0, rx_if.parity_error}, 0);
      check("reset frame_error", {31'd0, rx_if.frame_error}, 0);
      reset = 1'b0;
      idle(20);

      // 1: single byte with correct parity
      push_ev(EvByte, 8'h2D);
      send_frame(8'h2D, 1'b0, 1'b1);
      idle(20);
      wait_drain("t1 drain");

      // 2: byte sequence, each acked
      seq[0] = 8'h00; seq[1] = 8'h01; seq[2] = 8'h80; seq[3] = 8'hFF; seq[4] = 8'h63;
      for (int i = 0; i < 5; i++) begin
         push_ev(EvByte, seq[i]);
         send_frame(seq[i], 1'b0, 1'b1);
         idle(20);
      end
      wait_drain("t2 drain");

      // 3: bad parity is dropped, next byte still arrives
      push_ev(EvParity, 8'h00);
      send_frame(8'h03, 1'b1, 1'b1);
      idle(20);
      push_ev(EvByte, 8'h04);
      send_frame(8'h04, 1'b0, 1'b1);
      idle(20);
      wait_drain("t3 drain");

      // 4: low stop bit followed by a long break
      push_ev(EvFrame, 8'h00);
      send_frame(8'h55, 1'b0, 1'b0);
      rx_if.rx_line = 1'b0;
      repeat (50) @(negedge clock);
      idle(20);
      push_ev(EvByte, 8'hAA);
      send_frame(8'hAA, 1'b0, 1'b1);
      idle(20);
      wait_drain("t4 drain");

      // 5: short low glitch is not a frame
      rx_if.rx_line = 1'b0;
      repeat (4) @(negedge clock);
      idle(40);
      check("t5 received", {31'd0, rx_if.received}, 0);
      check("t5 rx_busy", {31'd0, rx_if.rx_busy}, 0);
      wait_drain("t5 no events");

      // 6: unacked byte blocks a following frame
      auto_ack = 1'b0;
      push_ev(EvByte, 8'h10);
      send_frame(8'h10, 1'b0, 1'b1);
      idle(20);
      wait_drain("t6 first byte");
      send_frame(8'h20, 1'b0, 1'b1);
      idle(20);
      check("t6 data_out held", {24'd0, rx_if.data_out}, 32'h10);
      check("t6 received held", {31'd0, rx_if.received}, 1);
      check("t6 rx_busy held", {31'd0, rx_if.rx_busy}, 1);
      manual_ack();
      idle(10);
      auto_ack = 1'b1;
      push_ev(EvByte, 8'h30);
      send_frame(8'h30, 1'b0, 1'b1);
      idle(20);
      wait_drain("t6 after ack");

      // Asynchronous reset in the middle of a frame
      rx_if.rx_line = 1'b0;
      repeat (CPB) @(negedge clock);
      rx_if.rx_line = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      check("pre-reset data_out", {24'd0, rx_if.data_out}, 32'h30);
      #2;
      reset = 1'b1;
      #1;
      check("async reset data_out", {24'd0, rx_if.data_out}, 0);
      check("async reset received", {31'd0, rx_if.received}, 0);
      check("async reset rx_busy", {31'd0, rx_if.rx_busy}, 0);
      check("async reset parity_error", {31'd0, rx_if.parity_error}, 0);
      check("async reset frame_error", {31'd0, rx_if.frame_error}, 0);
      @(negedge clock);
      rx_if.rx_line = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      idle(200);
      push_ev(EvByte, 8'h3C);
      send_frame(8'h3C, 1'b0, 1'b1);
      idle(20);
      wait_drain("post-reset byte");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
